// File: rtl/div_pkg.sv
// Shared types and default sizing for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;
  localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

  // Iteration counter width; a single-cycle divider still needs one bit.
  function automatic int cnt_width(input int dividend_w);
    return (dividend_w > 1) ? $clog2(dividend_w) : 1;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] p_in,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] p_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] trial;

  // The restored remainder is always below the divisor, so the low bits of the difference suffice.
  always_comb begin
    trial = {p_in, dvd_bit};
    q_bit = (trial >= {1'b0, divisor});
    p_out = q_bit ? (trial[DIVISOR_W-1:0] - divisor) : trial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/div_seq_restoring.sv
// Sequential restoring divider: one quotient bit per clock with a start/busy/done handshake.
module div_seq_restoring
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  p_q, p_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W-1:0]  step_p;
  logic                  step_q;

  div_restore_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .p_in    (p_q),
    .dvd_bit (dvd_q[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .p_out   (step_p),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      p_q         <= p_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Results change only on the edge entering DONE; a start in DONE is accepted like one in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    p_d         = p_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      RUN: begin
        p_d   = step_p;
        quo_d = DIVIDEND_W'({quo_q, step_q});
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          quotient_d  = DIVIDEND_W'({quo_q, step_q});
          remainder_d = step_p;
          dbz_d       = 1'b0;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          cnt_d = '0;
          p_d   = '0;
          quo_d = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_restoring.sv
// Directed and sweep bench for the sequential restoring divider.
module tb_div_seq_restoring;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int errors;
  int busyCnt;

  div_seq_restoring #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it, tallying cycles spent busy.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy === 1'b1) busyCnt++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present operands with start for one accepting edge, then drop start.
  task automatic applyStimulus(input logic [7:0] n, input logic [3:0] d);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    busyCnt  = 0;
    tick();
    start    = 1'b0;
  endtask

  // Bounded wait for done; returns the number of edges waited.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int doneSeen;
    logic [7:0] expQ;
    logic [3:0] expR;
    logic       expZ;

    checks   = 0;
    errors   = 0;
    busyCnt  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;

    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] 200 / 7");
    applyStimulus(8'd200, 4'd7);
    checkOutput("200_7_busy_after_accept", 32'(busy), 32'd1);
    waitDone(cyc);
    checkOutput("200_7_latency", 32'(cyc), 32'd8);
    checkOutput("200_7_busy_cycles", 32'(busyCnt), 32'd8);
    checkOutput("200_7_quotient", 32'(quotient), 32'd28);
    checkOutput("200_7_remainder", 32'(remainder), 32'd4);
    checkOutput("200_7_dbz", 32'(div_by_zero), 32'd0);
    tick();
    checkOutput("200_7_done_one_cycle", 32'(done), 32'd0);

    $display("[TB] start during RUN ignored");
    applyStimulus(8'd200, 4'd7);
    tick();
    tick();
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    checkOutput("ignored_start_still_busy", 32'(busy), 32'd1);
    waitDone(cyc);
    checkOutput("ignored_start_latency", 32'(cyc), 32'd5);
    checkOutput("ignored_start_quotient", 32'(quotient), 32'd28);
    checkOutput("ignored_start_remainder", 32'(remainder), 32'd4);
    tick();

    $display("[TB] back-to-back 255/15 then 5/9");
    applyStimulus(8'd255, 4'd15);
    waitDone(cyc);
    checkOutput("255_15_latency", 32'(cyc), 32'd8);
    checkOutput("255_15_quotient", 32'(quotient), 32'd17);
    checkOutput("255_15_remainder", 32'(remainder), 32'd0);
    dividend = 8'd5;
    divisor  = 4'd9;
    start    = 1'b1;
    busyCnt  = 0;
    tick();
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 4'd1;
    checkOutput("b2b_accepted_busy", 32'(busy), 32'd1);
    checkOutput("b2b_quotient_held", 32'(quotient), 32'd17);
    waitDone(cyc);
    checkOutput("5_9_latency", 32'(cyc), 32'd8);
    checkOutput("5_9_quotient", 32'(quotient), 32'd0);
    checkOutput("5_9_remainder", 32'(remainder), 32'd5);
    tick();

    $display("[TB] divide by zero");
    applyStimulus(8'd13, 4'd0);
    waitDone(cyc);
    checkOutput("dbz_latency", 32'(cyc), 32'd0);
    checkOutput("dbz_busy", 32'(busyCnt), 32'd0);
    checkOutput("dbz_quotient", 32'(quotient), 32'hFF);
    checkOutput("dbz_remainder", 32'(remainder), 32'd0);
    checkOutput("dbz_flag", 32'(div_by_zero), 32'd1);
    tick();
    checkOutput("dbz_done_one_cycle", 32'(done), 32'd0);
    checkOutput("dbz_flag_held", 32'(div_by_zero), 32'd1);
    applyStimulus(8'd200, 4'd7);
    checkOutput("dbz_flag_held_in_run", 32'(div_by_zero), 32'd1);
    waitDone(cyc);
    checkOutput("dbz_cleared_flag", 32'(div_by_zero), 32'd0);
    checkOutput("dbz_cleared_quotient", 32'(quotient), 32'd28);
    tick();

    $display("[TB] reset mid-RUN");
    applyStimulus(8'd99, 4'd4);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_quotient", 32'(quotient), 32'd0);
    checkOutput("midrst_remainder", 32'(remainder), 32'd0);
    checkOutput("midrst_dbz", 32'(div_by_zero), 32'd0);
    tick();
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0) doneSeen++;
    end
    checkOutput("midrst_no_done", 32'(doneSeen), 32'd0);

    $display("[TB] exhaustive sweep");
    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        if (d == 0) begin
          expQ = 8'hFF;
          expR = 4'd0;
          expZ = 1'b1;
        end else begin
          expQ = 8'(n / d);
          expR = 4'(n % d);
          expZ = 1'b0;
        end
        applyStimulus(8'(n), 4'(d));
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        waitDone(cyc);
        checkOutput($sformatf("sweep_lat_%0d_%0d", n, d), 32'(cyc), (d == 0) ? 32'd0 : 32'd8);
        checkOutput($sformatf("sweep_q_%0d_%0d", n, d), 32'(quotient), 32'(expQ));
        checkOutput($sformatf("sweep_r_%0d_%0d", n, d), 32'(remainder), 32'(expR));
        checkOutput($sformatf("sweep_z_%0d_%0d", n, d), 32'(div_by_zero), 32'(expZ));
        tick();
        checkOutput($sformatf("sweep_done1_%0d_%0d", n, d), 32'(done), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
